// File: rtl/kb_motion_scheduler_pkg.sv
// Shared types for the keyboard motion scheduler: key bit indices, axis directions,
// the pose-delta command shared with the pose unit, and FSM states.
package kb_motion_scheduler_pkg;

    localparam int KB_W    = 0;
    localparam int KB_S    = 1;
    localparam int KB_A    = 2;
    localparam int KB_D    = 3;
    localparam int KB_Q    = 4;
    localparam int KB_E    = 5;
    localparam int KB_UP   = 6;
    localparam int KB_DOWN = 7;

    typedef enum logic [1:0] {
        NEG  = 2'd0,
        ZERO = 2'd1,
        POS  = 2'd2
    } axis_dir_t;

    typedef struct packed {
        logic signed [7:0] dfwd;
        logic signed [7:0] dside;
        logic signed [7:0] dvert;
        logic signed [7:0] dyaw;
    } motion_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    // Opposing keys of one axis cancel out.
    function automatic axis_dir_t resolve_axis(input logic pos_key, input logic neg_key);
        if (pos_key && !neg_key) return POS;
        if (neg_key && !pos_key) return NEG;
        return ZERO;
    endfunction

    function automatic logic signed [7:0] scale_axis(input axis_dir_t dir, input logic [7:0] step);
        case (dir)
            POS:     return $signed(step);
            NEG:     return -$signed(step);
            default: return 8'sd0;
        endcase
    endfunction

endpackage

// File: rtl/kb_motion_scheduler_step_ramp.sv
// Step-size ramp: doubles the step while the same key set stays held, restarting
// at STEP_MIN whenever the key set changes or a frame carries no motion.
module motion_step_ramp #(
    parameter int STEP_MIN     = 1,
    parameter int STEP_MAX     = 16,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eval,
    input  logic       motion,
    input  logic [7:0] kb,
    output logic [7:0] step
);

    localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    logic [7:0]        step_q;
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]        prev_kb_q;
    logic [HOLD_W:0]   hold_inc;
    logic [7:0]        step_dbl;
    logic [7:0]        step_grown;
    logic              kb_changed;

    assign kb_changed = (kb != prev_kb_q);
    assign hold_inc   = {1'b0, hold_q} + 1'b1;
    assign step_dbl   = {step_q[6:0], 1'b0};
    assign step_grown = (step_dbl > 8'(STEP_MAX)) ? 8'(STEP_MAX) : step_dbl;

    // A new key set starts a fresh motion at the minimum step right away; doubling
    // only takes effect from the following frame.
    assign step = kb_changed ? 8'(STEP_MIN) : step_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q    <= 8'(STEP_MIN);
            hold_q    <= '0;
            prev_kb_q <= '0;
        end else if (eval) begin
            if (!motion) begin
                step_q    <= 8'(STEP_MIN);
                hold_q    <= '0;
                prev_kb_q <= '0;
            end else begin
                prev_kb_q <= kb;
                if (kb_changed) begin
                    step_q <= 8'(STEP_MIN);
                    hold_q <= '0;
                end else if (int'(hold_inc) >= ACCEL_FRAMES - 1) begin
                    step_q <= step_grown;
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_inc[HOLD_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/kb_motion_scheduler.sv
// Per-frame motion scheduler: key-state vector in, one pose-delta command per frame out.
// Step ramping is built only when MOTION_ACCEL_EN is defined; otherwise step is STEP_MIN.
module kb_motion_scheduler
    import kb_motion_scheduler_pkg::*;
#(
    parameter int STEP_MIN     = 1,
    parameter int STEP_MAX     = 16,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [7:0]        kb_in,
    input  logic              frame_start_in,
    input  logic              upd_ready_in,
    output logic              upd_valid_out,
    output logic signed [7:0] upd_dfwd_out,
    output logic signed [7:0] upd_dside_out,
    output logic signed [7:0] upd_dvert_out,
    output logic signed [7:0] upd_dyaw_out,
    output logic [7:0]        overrun_cnt_out
);

    localparam bit PARAMS_OK = (STEP_MIN >= 1) && (STEP_MAX <= 127) &&
                               (STEP_MAX >= STEP_MIN) && (ACCEL_FRAMES >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("kb_motion_scheduler: invalid STEP_MIN/STEP_MAX/ACCEL_FRAMES");
    end

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  kb_q;
    motion_cmd_t cmd_q;
    motion_cmd_t cmd_next;
    logic [7:0]  overrun_q;
    logic [7:0]  step;
    axis_dir_t   dir_fwd;
    axis_dir_t   dir_side;
    axis_dir_t   dir_vert;
    axis_dir_t   dir_yaw;
    logic        motion;

    assign dir_fwd  = resolve_axis(kb_q[KB_W],  kb_q[KB_S]);
    assign dir_side = resolve_axis(kb_q[KB_E],  kb_q[KB_Q]);
    assign dir_vert = resolve_axis(kb_q[KB_UP], kb_q[KB_DOWN]);
    assign dir_yaw  = resolve_axis(kb_q[KB_D],  kb_q[KB_A]);
    assign motion   = (dir_fwd != ZERO) || (dir_side != ZERO) ||
                      (dir_vert != ZERO) || (dir_yaw != ZERO);

    assign cmd_next.dfwd  = scale_axis(dir_fwd,  step);
    assign cmd_next.dside = scale_axis(dir_side, step);
    assign cmd_next.dvert = scale_axis(dir_vert, step);
    assign cmd_next.dyaw  = scale_axis(dir_yaw,  step);

`ifdef MOTION_ACCEL_EN
    motion_step_ramp #(
        .STEP_MIN    (STEP_MIN),
        .STEP_MAX    (STEP_MAX),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) u_ramp (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .eval  (state_q == COMPUTE),
        .motion(motion),
        .kb    (kb_q),
        .step  (step)
    );
`else
    assign step = 8'(STEP_MIN);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start_in) state_d = COMPUTE;
            COMPUTE: state_d = motion ? ISSUE : IDLE;
            ISSUE:   if (upd_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ticks seen outside IDLE are dropped and only counted; kb_in is not re-latched.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            kb_q      <= '0;
            cmd_q     <= '0;
            overrun_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && frame_start_in) kb_q <= kb_in;
            if (state_q == COMPUTE) cmd_q <= cmd_next;
            if (frame_start_in && state_q != IDLE && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
        end
    end

    assign upd_valid_out   = (state_q == ISSUE);
    assign upd_dfwd_out    = cmd_q.dfwd;
    assign upd_dside_out   = cmd_q.dside;
    assign upd_dvert_out   = cmd_q.dvert;
    assign upd_dyaw_out    = cmd_q.dyaw;
    assign overrun_cnt_out = overrun_q;

endmodule
